// File: rtl/alu_pkg.sv
// Shared definitions for the alu_seq operation sequencer and its 4-bit ALU datapath.
// Covers opcodes, FSM states, strobe and flag bit positions, and opcode classification helpers.
package alu_pkg;

  localparam int W_DEF = 4;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_MUL = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4;

  // Bit positions inside res_flags
  localparam int FLAG_SIGN  = 2;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_ZERO  = 0;

  // Bit positions inside the internal one-hot strobe vector
  localparam int STB_ADD = 0;
  localparam int STB_SUB = 1;
  localparam int STB_AND = 2;
  localparam int STB_MUL = 3;
  localparam int STB_DIV = 4;
  localparam int NSTB    = 5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_EXEC = 3'd2,
    ST_CAPT = 3'd3,
    ST_HOLD = 3'd4
  } state_t;

  function automatic logic op_legal(input logic [2:0] op);
    return (op <= OP_DIV);
  endfunction

  // MUL and DIV iterate over ITER exec cycles; the rest finish in one
  function automatic logic op_iter(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operation/result handshake bundle between an upstream issuer, alu_seq, and the result consumer.
interface alu_seq_if import alu_pkg::*; #(parameter int W = W_DEF);

  logic         op_valid;
  logic         op_ready;
  logic [2:0]   op_code;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_data;
  logic [2:0]   res_flags;
  logic         res_err;

  modport master (
    output op_valid, op_code, op_a, op_b, res_ready,
    input  op_ready, res_valid, res_data, res_flags, res_err
  );

  modport slave (
    input  op_valid, op_code, op_a, op_b, res_ready,
    output op_ready, res_valid, res_data, res_flags, res_err
  );

endinterface

// File: rtl/alu_strobe_dec.sv
// Opcode to one-hot ALU strobe decode, gated by an exec-active qualifier.
module alu_strobe_dec import alu_pkg::*; (
  input  logic [2:0]      op_code,
  input  logic            exec_en,
  output logic [NSTB-1:0] strobe
);

  // One-hot decode; illegal opcodes and idle cycles produce no strobe
  always_comb begin
    strobe = '0;
    if (exec_en) begin
      case (op_code)
        OP_ADD:  strobe[STB_ADD] = 1'b1;
        OP_SUB:  strobe[STB_SUB] = 1'b1;
        OP_AND:  strobe[STB_AND] = 1'b1;
        OP_MUL:  strobe[STB_MUL] = 1'b1;
        OP_DIV:  strobe[STB_DIV] = 1'b1;
        default: strobe = '0;
      endcase
    end else begin
      strobe = '0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequencer feeding the 4-bit ALU: latches one op, drives strobes for 1 or ITER cycles,
// then holds the captured result and flags until the consumer takes it.
module alu_seq import alu_pkg::*; #(
  parameter int W    = W_DEF,
  parameter int ITER = W_DEF
) (
  input  logic         clk,
  input  logic         clr,
  alu_seq_if.slave     bus,
  output logic [W-1:0] AH_in,
  output logic [W-1:0] BREG_in,
  output logic         alu_add,
  output logic         alu_sub,
  output logic         alu_and,
  output logic         alu_mul,
  output logic         alu_div,
  output logic         al_lsb,
  input  logic [W-1:0] ALU_out,
  input  logic         sign_flag,
  input  logic         carry_flag,
  input  logic         zero_flag
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t          state_r;
  logic [2:0]      op_code_r;
  logic [CW-1:0]   cnt_r;
  logic [NSTB-1:0] strobe_r;
  logic [NSTB-1:0] strobe_s;
  logic            exec_en_s;
  logic            al_lsb_r;
  logic [W-1:0]    ah_r;
  logic [W-1:0]    breg_r;
  logic            op_ready_r;
  logic            res_valid_r;
  logic [W-1:0]    res_data_r;
  logic [2:0]      res_flags_r;
  logic            res_err_r;

  // Strobes are registered, so the qualifier looks one cycle ahead: high whenever the next state is EXEC
  always_comb begin
    exec_en_s = 1'b0;
    if (state_r == ST_LOAD) begin
      exec_en_s = 1'b1;
    end else if (state_r == ST_EXEC) begin
      exec_en_s = op_iter(op_code_r) && (cnt_r != CNT_LAST);
    end else begin
      exec_en_s = 1'b0;
    end
  end

  alu_strobe_dec u_dec (
    .op_code (op_code_r),
    .exec_en (exec_en_s),
    .strobe  (strobe_s)
  );

  // Sequencer FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r     <= ST_IDLE;
      op_code_r   <= 3'd0;
      cnt_r       <= '0;
      strobe_r    <= '0;
      al_lsb_r    <= 1'b0;
      ah_r        <= '0;
      breg_r      <= '0;
      op_ready_r  <= 1'b1;
      res_valid_r <= 1'b0;
      res_data_r  <= '0;
      res_flags_r <= 3'd0;
      res_err_r   <= 1'b0;
    end else begin
      strobe_r <= strobe_s;
      al_lsb_r <= (state_r == ST_LOAD) && op_iter(op_code_r);
      case (state_r)
        ST_IDLE: begin
          if (bus.op_valid) begin
            op_code_r  <= bus.op_code;
            ah_r       <= bus.op_a;
            breg_r     <= bus.op_b;
            op_ready_r <= 1'b0;
            if (op_legal(bus.op_code)) begin
              state_r <= ST_LOAD;
            end else begin
              state_r     <= ST_HOLD;
              res_valid_r <= 1'b1;
              res_data_r  <= '0;
              res_flags_r <= 3'd0;
              res_err_r   <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          cnt_r   <= '0;
          state_r <= ST_EXEC;
        end
        ST_EXEC: begin
          if (op_iter(op_code_r) && (cnt_r != CNT_LAST)) begin
            cnt_r <= cnt_r + CNT_ONE;
          end else begin
            cnt_r   <= '0;
            state_r <= ST_CAPT;
          end
        end
        ST_CAPT: begin
          res_data_r  <= ALU_out;
          res_flags_r <= {sign_flag, carry_flag, zero_flag};
          res_err_r   <= 1'b0;
          res_valid_r <= 1'b1;
          state_r     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (bus.res_ready) begin
            res_valid_r <= 1'b0;
            res_err_r   <= 1'b0;
            op_ready_r  <= 1'b1;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          op_ready_r  <= 1'b1;
          res_valid_r <= 1'b0;
          strobe_r    <= '0;
        end
      endcase
    end
  end

  assign AH_in         = ah_r;
  assign BREG_in       = breg_r;
  assign alu_add       = strobe_r[STB_ADD];
  assign alu_sub       = strobe_r[STB_SUB];
  assign alu_and       = strobe_r[STB_AND];
  assign alu_mul       = strobe_r[STB_MUL];
  assign alu_div       = strobe_r[STB_DIV];
  assign al_lsb        = al_lsb_r;
  assign bus.op_ready  = op_ready_r;
  assign bus.res_valid = res_valid_r;
  assign bus.res_data  = res_data_r;
  assign bus.res_flags = res_flags_r;
  assign bus.res_err   = res_err_r;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq driving a small behavioural stand-in for the 4-bit ALU.
module tb_alu_seq;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       clr;
  logic [3:0] AH_in, BREG_in, ALU_out;
  logic       alu_add, alu_sub, alu_and, alu_mul, alu_div, al_lsb;
  logic       sign_flag, carry_flag, zero_flag;
  logic [3:0] alu_r = 4'd0;
  logic       alu_c = 1'b0;
  logic [7:0] prod_s;
  logic [4:0] stb_s;
  int         checks = 0;
  int         errors = 0;

  alu_seq_if #(.W(4)) bus ();

  alu_seq #(.W(4), .ITER(4)) dut (
    .clk        (clk),
    .clr        (clr),
    .bus        (bus),
    .AH_in      (AH_in),
    .BREG_in    (BREG_in),
    .alu_add    (alu_add),
    .alu_sub    (alu_sub),
    .alu_and    (alu_and),
    .alu_mul    (alu_mul),
    .alu_div    (alu_div),
    .al_lsb     (al_lsb),
    .ALU_out    (ALU_out),
    .sign_flag  (sign_flag),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag)
  );

  always #5 clk = ~clk;

  assign stb_s      = {alu_add, alu_sub, alu_and, alu_mul, alu_div};
  assign prod_s     = {4'd0, AH_in} * {4'd0, BREG_in};
  assign ALU_out    = alu_r;
  assign sign_flag  = alu_r[3];
  assign zero_flag  = (alu_r == 4'd0);
  assign carry_flag = alu_c;

  // ALU stand-in: result registers on each strobed edge
  always @(posedge clk) begin
    if (alu_add)      {alu_c, alu_r} <= {1'b0, AH_in} + {1'b0, BREG_in};
    else if (alu_sub) {alu_c, alu_r} <= {1'b0, AH_in} - {1'b0, BREG_in};
    else if (alu_and) {alu_c, alu_r} <= {1'b0, AH_in & BREG_in};
    else if (alu_mul) {alu_c, alu_r} <= {|prod_s[7:4], prod_s[3:0]};
    else if (alu_div) {alu_c, alu_r} <= (BREG_in == 4'd0) ? 5'h0F : {1'b0, AH_in / BREG_in};
  end

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op at the next edge (cycle 0) and check every cycle through op_ready's return
  task automatic run_op(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [4:0] mask, input int n_exec, input int v_cyc,
                        input logic [3:0] e_data, input logic [2:0] e_flags, input logic e_err);
    bus.op_code  = op;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.op_valid = 1'b1;
    tick();
    bus.op_valid = 1'b0;
    bus.op_a     = ~a;
    bus.op_b     = ~b;
    for (int c = 1; c <= v_cyc + 1; c++) begin
      if (c <= 2) begin
        check_val("AH_in", 8'(AH_in), 8'(a));
        check_val("BREG_in", 8'(BREG_in), 8'(b));
      end
      check_val("strobes", 8'(stb_s), (c >= 2 && c < 2 + n_exec) ? 8'(mask) : 8'd0);
      check_val("al_lsb", 8'(al_lsb), 8'(n_exec > 1 && c == 2));
      check_val("res_valid", 8'(bus.res_valid), 8'(c == v_cyc));
      check_val("op_ready", 8'(bus.op_ready), 8'(c == v_cyc + 1));
      if (c == v_cyc) begin
        check_val("res_data", 8'(bus.res_data), 8'(e_data));
        check_val("res_flags", 8'(bus.res_flags), 8'(e_flags));
        check_val("res_err", 8'(bus.res_err), 8'(e_err));
      end
      if (c != v_cyc + 1) tick();
    end
  endtask

  initial begin
    clr           = 1'b1;
    bus.op_valid  = 1'b1;
    bus.op_code   = OP_ADD;
    bus.op_a      = 4'd5;
    bus.op_b      = 4'd2;
    bus.res_ready = 1'b0;
    tick();
    tick();
    check_val("rst_op_ready", 8'(bus.op_ready), 8'd1);
    check_val("rst_strobes", 8'({stb_s, al_lsb}), 8'd0);
    check_val("rst_operands", {AH_in, BREG_in}, 8'd0);
    check_val("rst_res", {bus.res_valid, bus.res_err, bus.res_flags, 3'd0}, 8'd0);
    check_val("rst_res_data", 8'(bus.res_data), 8'd0);
    clr          = 1'b0;
    bus.op_valid = 1'b0;
    tick();
    check_val("post_rst_op_ready", 8'(bus.op_ready), 8'd1);
    check_val("post_rst_no_accept", 8'(stb_s), 8'd0);

    bus.res_ready = 1'b1;
    // 5+2=7; 5-2=3; 5&2=0 sets zero; 5*2=10 sets sign; 7/2=3; illegal op 6
    run_op(OP_ADD, 4'd5, 4'd2, 5'b10000, 1, 4, 4'd7, 3'b000, 1'b0);
    run_op(OP_SUB, 4'd5, 4'd2, 5'b01000, 1, 4, 4'd3, 3'b000, 1'b0);
    run_op(OP_AND, 4'd5, 4'd2, 5'b00100, 1, 4, 4'd0, 3'b001, 1'b0);
    run_op(OP_MUL, 4'd5, 4'd2, 5'b00010, 4, 7, 4'd10, 3'b100, 1'b0);
    run_op(OP_DIV, 4'd7, 4'd2, 5'b00001, 4, 7, 4'd3, 3'b000, 1'b0);
    run_op(3'd6, 4'd9, 4'd9, 5'b00000, 0, 1, 4'd0, 3'b000, 1'b1);

    // clr during the third MUL exec cycle
    bus.op_code  = OP_MUL;
    bus.op_a     = 4'd5;
    bus.op_b     = 4'd2;
    bus.op_valid = 1'b1;
    tick();
    bus.op_valid = 1'b0;
    tick();
    tick();
    tick();
    check_val("mul_3rd_strobe", 8'(stb_s), 8'b0000_0010);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_val("clr_mid_strobes", 8'({stb_s, al_lsb}), 8'd0);
    check_val("clr_mid_op_ready", 8'(bus.op_ready), 8'd1);
    for (int i = 0; i < 4; i++) begin
      check_val("clr_mid_no_valid", 8'(bus.res_valid), 8'd0);
      tick();
    end

    // Consumer stalls: 9+9 wraps to 2 with carry, held while op_valid is ignored
    bus.res_ready = 1'b0;
    bus.op_code   = OP_ADD;
    bus.op_a      = 4'd9;
    bus.op_b      = 4'd9;
    bus.op_valid  = 1'b1;
    tick();
    bus.op_code   = OP_SUB;
    bus.op_a      = 4'd1;
    bus.op_b      = 4'd1;
    tick();
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      check_val("stall_valid", 8'(bus.res_valid), 8'd1);
      check_val("stall_data", 8'(bus.res_data), 8'd2);
      check_val("stall_flags", 8'(bus.res_flags), 8'b0000_0010);
      check_val("stall_quiet", 8'({stb_s, bus.op_ready}), 8'd0);
      tick();
    end
    bus.op_valid  = 1'b0;
    bus.res_ready = 1'b1;
    tick();
    check_val("stall_release_valid", 8'(bus.res_valid), 8'd0);
    check_val("stall_release_ready", 8'(bus.op_ready), 8'd1);
    check_val("stall_release_data", 8'(bus.res_data), 8'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Operation sequencer that sits directly upstream of the 4-bit `alu` datapath. It accepts one operation at a time (opcode plus two operands) over a valid/ready handshake. It drives the ALU operand buses and the one-hot control strobes `alu_add`, `alu_sub`, `alu_and`, `alu_mul` and `alu_div` for the correct number of cycles. It then captures `ALU_out` and the sign/carry/zero flags into a held result register for the downstream consumer.

## Interface
Parameters:
- `W`, 4: operand/result width; must match the ALU datapath.
- `ITER`, 4: number of EXEC cycles for MUL and DIV; equals `W`.

Ports:
- `clk`  in  1: single clock; all state updates on rising edge.
- `clr`  in  1: reset, synchronous, active-high.
- `op_valid`  in  1: upstream offers an operation.
- `op_ready`  out  1: sequencer can accept; high only in IDLE.
- `op_code`  in  3: 0 ADD, 1 SUB, 2 AND, 3 MUL, 4 DIV, 5–7 illegal.
- `op_a`  in  W: first operand.
- `op_b`  in  W: second operand.
- `AH_in`  out  W: registered operand A to the ALU.
- `BREG_in`  out  W: registered operand B to the ALU.
- `alu_add`, `alu_sub`, `alu_and`, `alu_mul`, `alu_div`  out  1 each: one-hot ALU strobes; at most one high at any time.
- `al_lsb`  out  1: iteration-init strobe; high only in the first EXEC cycle of MUL/DIV.
- `ALU_out`  in  W: ALU result.
- `sign_flag`, `carry_flag`, `zero_flag`  in  1 each: ALU flags.
- `res_valid`  out  1: result held and valid.
- `res_ready`  in  1: downstream accepts the result.
- `res_data`  out  W: captured result.
- `res_flags`  out  3: {sign, carry, zero} as captured.
- `res_err`  out  1: high with `res_valid` if the opcode was illegal.

## Operation
States: IDLE, LOAD, EXEC, CAPT, HOLD.
- **IDLE:** `op_ready`=1. On `op_valid`: latch opcode, `AH_in`<=`op_a`, `BREG_in`<=`op_b`, then go to LOAD.
  - Illegal opcode: go straight to HOLD with `res_data`=0, `res_flags`=0, `res_err`=1.
- **LOAD:** one cycle; operands settle at the ALU, no strobe. Go to EXEC.
- **EXEC:** assert the strobe decoded from the latched opcode.
  - ADD/SUB/AND: one cycle.
  - MUL/DIV: exactly `ITER` consecutive cycles with the strobe held. `al_lsb` is high in the first of those cycles only. An iteration counter runs from 0 to `ITER`-1; at `ITER`-1 go to CAPT.
- **CAPT:** all strobes low. Register `ALU_out` to `res_data` and the flags to `res_flags`; `res_err`=0. Go to HOLD.
- **HOLD:** `res_valid`=1 and outputs stable. When `res_ready`=1, go to IDLE on the next edge. `res_valid` and `res_err` drop on that edge.
- `op_valid` outside IDLE is ignored; no queuing.
- `op_a`/`op_b` changing after acceptance have no effect.
- `clr` in any state, including mid-iteration: next edge forces IDLE.
  - Outputs after reset: counter 0, all strobes 0, `al_lsb`=0, `AH_in`=0, `BREG_in`=0, `res_valid`=0, `res_data`=0, `res_flags`=0, `res_err`=0, `op_ready`=1.
  - `clr` has priority over `op_valid` and `res_ready` in the same cycle.

## Timing
- The accept edge is cycle 0. Strobes are registered outputs, never combinational from inputs.
- ADD/SUB/AND: LOAD in cycle 1, strobe in cycle 2, capture at the end of cycle 3, `res_valid` from cycle 4.
- MUL/DIV: strobe in cycles 2 to 1+`ITER`, capture in cycle 2+`ITER`, `res_valid` from cycle 3+`ITER` (cycle 7 for `ITER`=4).
- Illegal opcode: `res_valid` from cycle 1.
- `res_ready` already high when HOLD is entered: `res_valid` is high for exactly one cycle and `op_ready` returns the following cycle.
- Minimum back-to-back issue interval: 5 cycles for single-cycle ops, 4+`ITER` for MUL/DIV.

## Structure
- Shared package `alu_pkg`:
  - opcode constants `OP_ADD`…`OP_DIV`;
  - state enum;
  - `W` default;
  - flag bit positions in `res_flags` (sign=2, carry=1, zero=0).
- One natural sub-module, `alu_strobe_dec`: combinational decode from opcode plus an exec-active qualifier to the one-hot strobe vector. Its output is registered in `alu_seq`.
- The bench instantiates `alu_seq` feeding the existing `alu`.

## Test plan
- Reset: hold `clr` high for 2 cycles with `op_valid`=1 -> all outputs at their reset values, no acceptance; `op_ready`=1 after `clr` drops.
- ADD, a=5, b=2, `res_ready`=1 -> `alu_add` high only in cycle 2; `res_valid` in cycle 4 with `res_data`=7, flags {0,0,0}.
- SUB 5-2, then AND 5&2 back-to-back -> `res_data`=3, then `res_data`=0 with zero flag=1. Only the matching strobe fires for each; the second op is accepted 5 cycles after the first.
- MUL a=5, b=2 -> `alu_mul` high for 4 consecutive cycles, `al_lsb` high in the first only; `res_valid` in cycle 7; `res_data` equals the ALU low nibble.
- Illegal opcode 6 -> `res_valid` in cycle 1 with `res_err`=1 and `res_data`=0; no strobe is ever asserted.
- Corner cases:
  - `clr` pulsed during the 3rd MUL cycle -> strobes drop next edge, state is IDLE, no `res_valid`.
  - `res_ready` held low for 10 cycles -> `res_data`, `res_flags` and `res_valid` stay stable and `op_valid` is ignored.
